// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator.
// Boot/run/halt sequencing, redirects and misaligned-target trapping.
module pc_gen #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VEC = '0,
  parameter bit C_EXT = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  fetch_ready,
  input  logic                  branch_taken,
  input  logic [DATA_WIDTH-1:0] branch_pc,
  input  logic                  jalr,
  input  logic [DATA_WIDTH-1:0] jalr_base,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic                  trap,
  input  logic [DATA_WIDTH-1:0] trap_vec,
  input  logic                  halt_req,
  input  logic                  resume,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] pc_plus4,
  output logic                  pc_valid,
  output logic                  misalign_err,
  output logic [DATA_WIDTH-1:0] err_addr,
  output logic                  halted
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [DATA_WIDTH-1:0] FOUR =
    DATA_WIDTH'(4);

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   pc_q, pc_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   eaddr_q, eaddr_d;

  logic [DATA_WIDTH-1:0]   jalr_sum;
  logic [DATA_WIDTH-1:0]   jalr_tgt;
  logic [DATA_WIDTH-1:0]   br_tgt;
  logic [DATA_WIDTH-1:0]   tgt;
  logic                    mis;

  logic                    sel_trap;
  logic                    sel_jalr;
  logic                    sel_br;
  logic                    sel_adv;

  // Target arithmetic, wrapping modulo 2^DATA_WIDTH.
  always_comb begin
    pc_plus4 = pc_q + FOUR;
    jalr_sum = jalr_base + imm;
    jalr_tgt = {jalr_sum[DATA_WIDTH-1:1], 1'b0};
    br_tgt   = branch_pc + imm;
    tgt      = sel_jalr ? jalr_tgt : br_tgt;
    if (C_EXT)
      mis = tgt[0];
    else
      mis = |tgt[1:0];
  end

  // One-hot next-PC source, trap highest priority.
  always_comb begin
    sel_trap = trap;
    sel_jalr = jalr & ~trap;
    sel_br   = branch_taken & ~trap & ~jalr;
    sel_adv  = fetch_ready & ~stall
             & ~trap & ~jalr & ~branch_taken;
  end

  // Next-state, next-PC and error capture.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = 1'b0;
    eaddr_d = eaddr_q;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        unique case (1'b1)
          sel_trap: pc_d = trap_vec;
          sel_jalr,
          sel_br: begin
            if (mis) begin
              pc_d    = trap_vec;
              err_d   = 1'b1;
              eaddr_d = tgt;
            end else begin
              pc_d = tgt;
            end
          end
          sel_adv: pc_d = pc_plus4;
          default: pc_d = pc_q;
        endcase
        if (halt_req)
          state_d = HALT;
      end
      HALT: begin
        if (trap) begin
          pc_d    = trap_vec;
          state_d = RUN;
        end else if (resume) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State and PC registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_VEC;
      err_q   <= 1'b0;
      eaddr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
      eaddr_q <= eaddr_d;
    end
  end

  assign pc           = pc_q;
  assign pc_valid     = (state_q == RUN);
  assign halted       = (state_q == HALT);
  assign misalign_err = err_q;
  assign err_addr     = eaddr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen.
// Expected values are hand-computed per vector.
module tb_pc_gen;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        fetch_ready;
  logic        branch_taken;
  logic [31:0] branch_pc;
  logic        jalr;
  logic [31:0] jalr_base;
  logic [31:0] imm;
  logic        trap;
  logic [31:0] trap_vec;
  logic        halt_req;
  logic        resume;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_valid;
  logic        misalign_err;
  logic [31:0] err_addr;
  logic        halted;

  int checks;
  int failures;

  pc_gen #(
    .DATA_WIDTH(32),
    .RESET_VEC (32'h0000_0000),
    .C_EXT     (1'b0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .fetch_ready (fetch_ready),
    .branch_taken(branch_taken),
    .branch_pc   (branch_pc),
    .jalr        (jalr),
    .jalr_base   (jalr_base),
    .imm         (imm),
    .trap        (trap),
    .trap_vec    (trap_vec),
    .halt_req    (halt_req),
    .resume      (resume),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .pc_valid    (pc_valid),
    .misalign_err(misalign_err),
    .err_addr    (err_addr),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_st(
    input string       tag,
    input logic [31:0] epc,
    input logic        ev,
    input logic        eh
  );
    check({tag, ".pc"}, pc, epc);
    check({tag, ".valid"}, 32'(pc_valid), 32'(ev));
    check({tag, ".halted"}, 32'(halted), 32'(eh));
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b0;
    stall        = 1'b0;
    fetch_ready  = 1'b1;
    branch_taken = 1'b0;
    branch_pc    = '0;
    jalr         = 1'b0;
    jalr_base    = '0;
    imm          = '0;
    trap         = 1'b0;
    trap_vec     = 32'h0000_0200;
    halt_req     = 1'b0;
    resume       = 1'b0;

    // reset
    tick();
    tick();
    chk_st("rst", 32'h0, 1'b0, 1'b0);
    check("rst.err", 32'(misalign_err), 32'h0);
    check("rst.eaddr", err_addr, 32'h0);
    check("rst.p4", pc_plus4, 32'h4);
    rst = 1'b1;
    #1;
    chk_st("boot", 32'h0, 1'b0, 1'b0);

    // boot then sequential fetch
    tick();
    chk_st("run0", 32'h0, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("seq", pc, 32'(i * 4));
    end

    // stall holds pc
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall", pc, 32'h10);
    end
    stall = 1'b0;
    tick();
    check("unstall", pc, 32'h14);

    // branch overrides stall
    stall        = 1'b1;
    branch_taken = 1'b1;
    branch_pc    = 32'h20;
    imm          = 32'hFFFF_FFF8;
    tick();
    check("br", pc, 32'h18);
    check("br.err", 32'(misalign_err), 32'h0);

    // misaligned branch
    imm = 32'h6;
    tick();
    check("brmis", pc, 32'h200);
    check("brmis.err", 32'(misalign_err), 32'h1);
    check("brmis.ea", err_addr, 32'h26);
    branch_taken = 1'b0;
    stall        = 1'b0;
    fetch_ready  = 1'b0;
    tick();
    check("hold", pc, 32'h200);
    check("pulse", 32'(misalign_err), 32'h0);
    check("sticky", err_addr, 32'h26);

    // jalr clears bit0
    jalr      = 1'b1;
    jalr_base = 32'h101;
    imm       = 32'h3;
    tick();
    check("jalr", pc, 32'h104);
    check("jalr.err", 32'(misalign_err), 32'h0);

    // jalr misaligned in bit1
    jalr_base = 32'h100;
    imm       = 32'h2;
    tick();
    check("jmis", pc, 32'h200);
    check("jmis.ea", err_addr, 32'h102);
    check("jmis.err", 32'(misalign_err), 32'h1);

    // trap wins over jalr and branch
    jalr_base    = 32'h100;
    imm          = 32'h40;
    branch_taken = 1'b1;
    branch_pc    = 32'h80;
    trap         = 1'b1;
    trap_vec     = 32'h300;
    tick();
    check("trap", pc, 32'h300);
    check("trap.err", 32'(misalign_err), 32'h0);
    trap         = 1'b0;
    jalr         = 1'b0;
    branch_taken = 1'b0;

    // halt after this cycle's advance
    fetch_ready = 1'b1;
    halt_req    = 1'b1;
    tick();
    chk_st("halt", 32'h304, 1'b0, 1'b1);
    halt_req     = 1'b0;
    branch_taken = 1'b1;
    branch_pc    = 32'h40;
    imm          = 32'h0;
    tick();
    chk_st("hbr", 32'h304, 1'b0, 1'b1);
    branch_taken = 1'b0;

    // resume beats halt_req
    halt_req    = 1'b1;
    resume      = 1'b1;
    fetch_ready = 1'b0;
    tick();
    chk_st("resume", 32'h304, 1'b1, 1'b0);
    resume = 1'b0;
    tick();
    chk_st("halt2", 32'h304, 1'b0, 1'b1);
    halt_req = 1'b0;

    // trap leaves halt
    trap     = 1'b1;
    trap_vec = 32'hFFFF_FFFC;
    tick();
    chk_st("htrap", 32'hFFFF_FFFC, 1'b1, 1'b0);
    trap = 1'b0;
    check("p4wrap", pc_plus4, 32'h0);

    // wrap on advance
    fetch_ready = 1'b1;
    tick();
    check("wrap", pc, 32'h0);

    // branch wrap
    branch_taken = 1'b1;
    branch_pc    = 32'hFFFF_FFF0;
    imm          = 32'h20;
    tick();
    check("brwrap", pc, 32'h10);
    branch_taken = 1'b0;

    // async reset mid-halt
    halt_req = 1'b1;
    tick();
    chk_st("halt3", 32'h14, 1'b0, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk_st("arst", 32'h0, 1'b0, 1'b0);
    check("arst.ea", err_addr, 32'h0);
    halt_req = 1'b0;
    tick();
    rst  = 1'b1;
    trap = 1'b1;
    #1;
    chk_st("boot2", 32'h0, 1'b0, 1'b0);
    tick();
    chk_st("bootign", 32'h0, 1'b1, 1'b0);
    trap = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
